// File: rtl/maze_dfs_controller.sv
// Depth-first maze search sequencer. It walks an N x N bit-map and uses an external 2-bit direction stack for backtracking.
// Define MAZE_STEP_COUNT_EN to add a saturating step_count output that counts stack pushes and pops.
module maze_dfs_controller #(
  parameter int N  = 16,
  parameter int AW = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  output logic [2*AW-1:0] mem_addr,
  output logic            mem_rd,
  input  logic            mem_rd_data,
  output logic            mem_wr,
  output logic            stk_push,
  output logic            stk_pop,
  output logic            stk_init,
  output logic [1:0]      stk_data_in,
  input  logic [1:0]      stk_data_out,
  input  logic            stk_full,
  input  logic            stk_empty,
  output logic [AW-1:0]   cur_row,
  output logic [AW-1:0]   cur_col,
  output logic            busy,
  output logic            done,
`ifdef MAZE_STEP_COUNT_EN
  output logic [15:0]     step_count,
`endif
  output logic            fail
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_CHK, S_MARK, S_TRY, S_WAIT, S_BACK, S_DONE, S_FAIL
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     row_q, row_d, col_q, col_d;
  logic [2:0]        dir_q, dir_d;
  logic [2*AW-1:0]   addr_q, addr_d;
  logic              rd_q, rd_d, wr_q, wr_d, init_q, init_d;
  logic              busy_q, done_q, fail_q;
  logic [1:0]        back_dir;

  function automatic logic in_bounds(input logic [AW-1:0] r, input logic [AW-1:0] c,
                                     input logic [1:0] d);
    case (d)
      2'd0:    in_bounds = (r != '0);
      2'd1:    in_bounds = (c != LAST);
      2'd2:    in_bounds = (r != LAST);
      default: in_bounds = (c != '0);
    endcase
  endfunction

  function automatic logic [2*AW-1:0] step_addr(input logic [AW-1:0] r, input logic [AW-1:0] c,
                                                input logic [1:0] d);
    logic [AW-1:0] nr, nc;
    nr = r;
    nc = c;
    case (d)
      2'd0:    nr = r - AW'(1);
      2'd1:    nc = c + AW'(1);
      2'd2:    nr = r + AW'(1);
      default: nc = c - AW'(1);
    endcase
    step_addr = {nr, nc};
  endfunction

  // Flipping bit 1 of a direction gives the opposite direction.
  assign back_dir = stk_data_out ^ 2'b10;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    dir_d       = dir_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = 2'b00;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d = S_INIT;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_INIT: state_d = S_CHK;
      S_CHK:  state_d = mem_rd_data ? S_FAIL : S_MARK;
      S_MARK: begin
        if (row_q == LAST && col_q == LAST) begin
          state_d = S_DONE;
        end else begin
          dir_d   = 3'd0;
          state_d = S_TRY;
        end
      end
      S_TRY: begin
        if (dir_q[2])                                 state_d = S_BACK;
        else if (!in_bounds(row_q, col_q, dir_q[1:0])) dir_d   = dir_q + 3'd1;
        else                                           state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rd_data) begin
          dir_d   = dir_q + 3'd1;
          state_d = S_TRY;
        end else if (stk_full) begin
          state_d = S_FAIL;
        end else begin
          stk_push       = 1'b1;
          stk_data_in    = dir_q[1:0];
          {row_d, col_d} = step_addr(row_q, col_q, dir_q[1:0]);
          state_d        = S_MARK;
        end
      end
      S_BACK: begin
        if (stk_empty) begin
          state_d = S_FAIL;
        end else begin
          stk_pop        = 1'b1;
          {row_d, col_d} = step_addr(row_q, col_q, back_dir);
          dir_d          = {1'b0, stk_data_out} + 3'd1;
          state_d        = S_TRY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Memory strobes are looked ahead from the next state so they leave a register.
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    init_d = 1'b0;
    addr_d = '0;
    case (state_d)
      S_INIT: begin
        rd_d   = 1'b1;
        init_d = 1'b1;
      end
      S_MARK: begin
        wr_d   = 1'b1;
        addr_d = {row_d, col_d};
      end
      S_TRY: begin
        if (!dir_d[2] && in_bounds(row_d, col_d, dir_d[1:0])) begin
          rd_d   = 1'b1;
          addr_d = step_addr(row_d, col_d, dir_d[1:0]);
        end
      end
      default: ;
    endcase
  end

`ifdef MAZE_STEP_COUNT_EN
  logic [15:0] step_q;
  assign step_count = step_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      dir_q   <= 3'd0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
`ifdef MAZE_STEP_COUNT_EN
      step_q  <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      init_q  <= init_d;
      busy_q  <= !(state_d inside {S_IDLE, S_DONE, S_FAIL});
      done_q  <= (state_d == S_DONE);
      fail_q  <= (state_d == S_FAIL);
`ifdef MAZE_STEP_COUNT_EN
      if (state_d == S_INIT)
        step_q <= 16'd0;
      else if ((stk_push || stk_pop) && step_q != 16'hFFFF)
        step_q <= step_q + 16'd1;
`endif
    end
  end

  assign mem_addr = addr_q;
  assign mem_rd   = rd_q;
  assign mem_wr   = wr_q;
  assign stk_init = init_q;
  assign cur_row  = row_q;
  assign cur_col  = col_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fail     = fail_q;

endmodule

// File: tb/tb_maze_dfs_controller.sv
// Directed bench for maze_dfs_controller: behavioural maze memory and direction stack around the DUT,
// with hand-computed expectations for the standard 16x16 scenarios.
module tb_maze_dfs_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_rd, mem_wr, rd_q = 1'b0;
  logic       stk_push, stk_pop, stk_init;
  logic [1:0] stk_data_in, stk_data_out;
  logic       stk_full, stk_empty;
  logic [3:0] cur_row, cur_col;
  logic       busy, done, fail;
`ifdef MAZE_STEP_COUNT_EN
  logic [15:0] step_count;
`endif

  int checks = 0;
  int failures = 0;

  logic       maze [0:255];
  logic [1:0] stk [0:256];
  logic [1:0] pop_log [0:1023];
  int         sp = 0, push_cnt = 0, pop_cnt = 0, wr_cnt = 0;
  logic       wr_goal = 1'b0;
  logic       load_req = 1'b0;
  int         load_pat = 0;
  int         cyc;

  always #5 clock = ~clock;

  maze_dfs_controller dut (
    .clock(clock), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rd_data(rd_q), .mem_wr(mem_wr),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_init(stk_init),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
    .stk_full(stk_full), .stk_empty(stk_empty),
    .cur_row(cur_row), .cur_col(cur_col),
    .busy(busy), .done(done),
`ifdef MAZE_STEP_COUNT_EN
    .step_count(step_count),
`endif
    .fail(fail)
  );

  function automatic logic pat_bit(input int p, input int idx);
    int r, c;
    r = idx / 16;
    c = idx % 16;
    case (p)
      1:       pat_bit = (idx == 0);
      2:       pat_bit = !((r == 0 && c <= 2) || c == 0 || r == 15);
      3:       pat_bit = (r == 14 && c == 15) || (r == 15 && c == 14);
      default: pat_bit = 1'b0;
    endcase
  endfunction

  assign stk_data_out = (sp > 0) ? stk[sp-1] : 2'b00;
  assign stk_full     = (sp >= 256);
  assign stk_empty    = (sp == 0);

  always @(posedge clock) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) maze[i] <= pat_bit(load_pat, i);
    end else if (mem_wr) begin
      maze[mem_addr] <= 1'b1;
    end
    if (mem_rd) rd_q <= maze[mem_addr];
    if (stk_init) begin
      sp <= 0; push_cnt <= 0; pop_cnt <= 0; wr_cnt <= 0; wr_goal <= 1'b0;
    end else begin
      if (stk_push) begin
        stk[sp]  <= stk_data_in;
        sp       <= sp + 1;
        push_cnt <= push_cnt + 1;
      end else if (stk_pop) begin
        pop_log[pop_cnt] <= stk_data_out;
        sp               <= sp - 1;
        pop_cnt          <= pop_cnt + 1;
      end
      if (mem_wr) begin
        wr_cnt <= wr_cnt + 1;
        if (mem_addr == 8'hFF) wr_goal <= 1'b1;
      end
    end
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic load_maze(input int p);
    load_pat = p;
    load_req = 1'b1;
    @(posedge clock); #1;
    load_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int n);
    n = 0;
    while (!(done || fail) && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check_eq("end_reached", int'(done || fail), 1);
  endtask

  task automatic check_case1(input string tag);
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_fail"}, fail, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_pushes"}, push_cnt, 30);
    check_eq({tag, "_pops"}, pop_cnt, 0);
    check_eq({tag, "_row"}, cur_row, 15);
    check_eq({tag, "_col"}, cur_col, 15);
    check_eq({tag, "_stk0"}, stk[0], 1);
    check_eq({tag, "_stk14"}, stk[14], 1);
    check_eq({tag, "_stk15"}, stk[15], 2);
    check_eq({tag, "_stk29"}, stk[29], 2);
  endtask

  initial begin
    int ones, k;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_fail", fail, 0);
    check_eq("rst_rd", mem_rd, 0);
    check_eq("rst_wr", mem_wr, 0);
    check_eq("rst_init", stk_init, 0);
    check_eq("rst_push", stk_push, 0);
    check_eq("rst_pop", stk_pop, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_din", stk_data_in, 0);
    check_eq("rst_cur", {cur_row, cur_col}, 0);

    // Case 1: open maze, right along row 0 then down column 15.
    load_maze(0);
    pulse_start();
    check_eq("c1_init", stk_init, 1);
    wait_end(2000, cyc);
    check_eq("c1_latency", cyc, 152);
    check_case1("c1");
`ifdef MAZE_STEP_COUNT_EN
    check_eq("c1_steps", step_count, 30);
`endif

    // Case 2: blocked start cell.
    load_maze(1);
    pulse_start();
    check_eq("c2_init", stk_init, 1);
    check_eq("c2_rd", mem_rd, 1);
    check_eq("c2_addr", mem_addr, 0);
    check_eq("c2_done_clr", done, 0);
    check_eq("c2_busy", busy, 1);
    @(posedge clock); #1;
    check_eq("c2_fail_early", fail, 0);
    @(posedge clock); #1;
    check_eq("c2_fail", fail, 1);
    check_eq("c2_busy_end", busy, 0);
    check_eq("c2_writes", wr_cnt, 0);
    check_eq("c2_pushes", push_cnt, 0);

    // Case 3: dead end at (0,1),(0,2) before the real path.
    load_maze(2);
    pulse_start();
    check_eq("c3_fail_clr", fail, 0);
    wait_end(2000, cyc);
    check_eq("c3_done", done, 1);
    check_eq("c3_pops", pop_cnt, 2);
    check_eq("c3_pop0", pop_log[0], 1);
    check_eq("c3_pop1", pop_log[1], 1);
    check_eq("c3_depth", sp, 30);
    check_eq("c3_pushes", push_cnt, 32);
    check_eq("c3_cur", {cur_row, cur_col}, 8'hFF);
    check_eq("c3_stk0", stk[0], 2);
    check_eq("c3_stk29", stk[29], 1);
`ifdef MAZE_STEP_COUNT_EN
    check_eq("c3_steps", step_count, 34);
`endif

    // Case 4: goal sealed off, exhaustive search then failure.
    load_maze(3);
    pulse_start();
    wait_end(20000, cyc);
    check_eq("c4_fail", fail, 1);
    check_eq("c4_done", done, 0);
    check_eq("c4_empty", stk_empty, 1);
    check_eq("c4_writes", wr_cnt, 253);
    check_eq("c4_goal_wr", wr_goal, 0);
    ones = 0;
    for (int i = 0; i < 256; i++) ones += int'(maze[i]);
    check_eq("c4_ones", ones, 255);
    check_eq("c4_goal_cell", maze[255], 0);
    check_eq("c4_pushpop", push_cnt, pop_cnt);

    // Case 5: reset while waiting on a neighbour read.
    load_maze(0);
    pulse_start();
    k = 0;
    while (!(mem_rd && !stk_init) && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    check_eq("c5_probe_seen", int'(k < 100), 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_eq("c5_busy", busy, 0);
    check_eq("c5_strobes", {mem_rd, mem_wr, stk_push, stk_pop, stk_init}, 0);
    check_eq("c5_cur", {cur_row, cur_col}, 0);
    load_maze(0);
    pulse_start();
    wait_end(2000, cyc);
    check_eq("c5_latency", cyc, 152);
    check_case1("c5");

    // Case 6: start while busy is ignored; start from DONE restarts.
    load_maze(0);
    pulse_start();
    repeat (20) @(posedge clock);
    #1;
    pulse_start();
    check_eq("c6_busy_init", stk_init, 0);
    check_eq("c6_busy", busy, 1);
    wait_end(2000, cyc);
    check_case1("c6a");
    load_maze(0);
    pulse_start();
    check_eq("c6_restart_init", stk_init, 1);
    check_eq("c6_restart_done", done, 0);
    check_eq("c6_restart_busy", busy, 1);
    wait_end(2000, cyc);
    check_eq("c6_latency", cyc, 152);
    check_case1("c6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maze_dfs_controller.md
Name: maze_dfs_controller

Overview:
Sequencer for the Binary Maze solver. It runs a depth-first search over an N x N bit-map maze held in external single-port maze memory (1 = wall or visited, 0 = free). It uses the 2-bit direction stack as its backtrack store: each successful move pushes its direction, and each dead end pops one. When it stops, the stack holds the path from the start cell (0,0) to the goal cell (N-1,N-1).

Parameters:
N, 16, maze side length; must be a power of 2 with N*N <= 256.
AW, $clog2(N), width of the row and column coordinates.

Ports:
clock  in  1  system clock; everything is updated on its rising edge
reset  in  1  synchronous, active-high; clears all state to the reset values below
start  in  1  one-cycle request to begin a search; sampled only in IDLE, DONE or FAIL
mem_addr  out  2*AW  maze memory address {row,col}
mem_rd  out  1  maze read strobe; mem_rd_data is valid on the next cycle
mem_rd_data  in  1  maze read data
mem_wr  out  1  maze write strobe; always writes 1 to mem_addr (visited mark)
stk_push  out  1  stack push
stk_pop  out  1  stack pop
stk_init  out  1  stack clear
stk_data_in  out  2  direction to push
stk_data_out  in  2  stack top-of-stack value (combinational)
stk_full  in  1  stack full flag
stk_empty  in  1  stack empty flag
cur_row  out  AW  current cell row
cur_col  out  AW  current cell column
busy  out  1  search in progress
done  out  1  goal reached; level signal
fail  out  1  no path exists or stack overflow; level signal

Behaviour:
- Reset values:
  - state = IDLE.
  - cur_row, cur_col, dir = 0.
  - done, fail, busy = 0.
  - All strobes (mem_rd, mem_wr, stk_push, stk_pop, stk_init) = 0.
  - mem_addr and stk_data_in = 0.
  - reset has priority over start.
- Directions: 0 = up (row-1), 1 = right (col+1), 2 = down (row+1), 3 = left (col-1). dir is a 3-bit register; the value 4 means "all directions tried".
- All strobes are single-cycle Moore outputs of the states listed below.
- IDLE, DONE, FAIL: when start=1, go to INIT and clear done and fail. Otherwise hold. start is ignored in all other states.
- INIT: stk_init=1, cur=(0,0), mem_rd=1 at (0,0). Go to CHK.
- CHK: if mem_rd_data=1, go to FAIL. Otherwise go to MARK.
- MARK: mem_wr=1 at cur. If cur=(N-1,N-1), go to DONE. Otherwise set dir=0 and go to TRY.
- TRY:
  - If dir=4, go to BACK.
  - Else if the neighbour in direction dir is out of bounds, dir++ and stay in TRY.
  - Else mem_rd=1 at the neighbour and go to WAIT.
- WAIT:
  - If mem_rd_data=1, dir++ and go to TRY.
  - Else if stk_full=1, go to FAIL.
  - Else stk_push=1 with stk_data_in=dir[1:0], cur = neighbour, go to MARK.
- BACK:
  - If stk_empty=1, go to FAIL.
  - Else stk_pop=1, capture d = stk_data_out in the same cycle, move cur one step opposite to d, set dir = d+1, go to TRY.
- busy = 1 in every state except IDLE, DONE and FAIL. done = (state==DONE). fail = (state==FAIL).
- Latency: the search ends at the earliest 3 edges after the start-sampling edge (start cell == goal cell, N=1). Each move costs 2 cycles per direction probed plus 1 MARK cycle.
- Coordinates never wrap; bounds are checked before any read.
- The maze contents are destroyed by the search, because every visited cell is written to 1. The maze must be reloaded before the next start.
- Reset during a search returns to IDLE on the next cycle. The stack is re-initialised on the next start through stk_init.

Optional Feature:
MAZE_STEP_COUNT_EN
- Defined: adds an output step_count (16 bits, reset 0, cleared in INIT). It increments on every stk_push or stk_pop and saturates at 16'hFFFF.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. All-zero 16x16 maze, start pulse -> path goes right along row 0, then down col 15. done=1, 30 pushes, 0 pops, cur=(15,15).
2. Cell (0,0)=1, start pulse -> fail=1 two edges after INIT. No mem_wr, no push.
3. Open cells only (0,0..2), col 0 rows 0..15, row 15 -> enters dead end (0,1),(0,2) first. Exactly 2 pops (d=1, d=1), then down col 0 and along row 15. done=1, stack depth 30.
4. All-zero maze except (14,15)=1 and (15,14)=1 -> full exploration, fail=1 with stk_empty=1. Every reachable cell is written 1; (15,15) is never written.
5. reset asserted mid-search in WAIT -> next cycle busy=0 and all strobes 0. After reloading the maze, a new start completes case 1 correctly.
6. start pulsed while busy -> ignored. start in DONE with a reloaded maze -> a new run begins with stk_init=1 and done cleared.
